// File: rtl/cpu_multicycle_ctrl_if.sv
// rtl/cpu_multicycle_ctrl_if.sv - instruction-fetch handshake bundle between control FSM and instruction memory
interface cpu_multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/cpu_multicycle_ctrl.sv
// rtl/cpu_multicycle_ctrl.sv - multi-cycle control FSM owning PC/IR; optional retire counter under CTRL_PERF_CNT_EN
module cpu_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_multicycle_ctrl_if.master imem,
  input  logic                 alu_zero,
  output logic [31:0]          pc,
  output logic [31:0]          ir,
  output logic                 alu_en,
  output logic                 rf_we,
  output logic                 halted,
  output logic                 illegal,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4,
    S_JUMP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t      cur, nxt;
  logic [31:0] pc_nxt, ir_nxt;
  logic        illegal_set;
  logic [5:0]  op;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;

  assign op       = ir[31:26];
  assign pc_plus4 = pc + 32'd4;
  // branch displacement is a signed word offset relative to pc+4
  assign br_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
  assign state    = cur;

  // state, PC, IR and sticky illegal flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      pc  <= pc_nxt;
      ir  <= ir_nxt;
      if (illegal_set) illegal <= 1'b1;
    end
  end

  // next-state, next-PC/IR and Moore strobes
  always_comb begin
    nxt           = cur;
    pc_nxt        = pc;
    ir_nxt        = ir;
    illegal_set   = 1'b0;
    imem.imem_req = 1'b0;
    alu_en        = 1'b0;
    rf_we         = 1'b0;
    halted        = 1'b0;
    case (cur)
      S_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          ir_nxt = imem.imem_rdata;
          nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op <= 6'd7) begin
          nxt = S_EXEC;
        end else if (op == 6'd8) begin
          nxt = S_BRANCH;
        end else if (op == 6'd9) begin
          nxt = S_JUMP;
        end else if (op == 6'd63) begin
          nxt = S_HALT;
        end else begin
          // unsupported opcode: skip it without retiring
          illegal_set = 1'b1;
          pc_nxt      = pc_plus4;
          nxt         = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        nxt    = S_WB;
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_nxt = pc_plus4;
        nxt    = S_FETCH;
      end
      S_BRANCH: begin
        alu_en = 1'b1;
        pc_nxt = alu_zero ? (pc_plus4 + br_off) : pc_plus4;
        nxt    = S_FETCH;
      end
      S_JUMP: begin
        pc_nxt = {pc[31:28], ir[25:0], 2'b00};
        nxt    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        nxt = S_FETCH;
      end
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic                 retire;
  logic [CNT_WIDTH-1:0] cnt;

  // HALT counts on entry since the FSM never leaves it
  assign retire = (cur == S_WB) || (cur == S_BRANCH) || (cur == S_JUMP) ||
                  ((cur == S_DECODE) && (op == 6'd63));

  // saturating retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (retire && (cnt != {CNT_WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign instr_count = cnt;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// tb/tb_cpu_multicycle_ctrl.sv - randomized self-checking bench for cpu_multicycle_ctrl against an instruction-level model
module tb_cpu_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        ready, ready2;
  logic [31:0] rdata;
  logic        alu_zero;

  logic [31:0] pc, ir, pc2, ir2;
  logic        alu_en, rf_we, halted, illegal;
  logic        alu_en2, rf_we2, halted2, illegal2;
  logic [2:0]  state, state2;
  logic [15:0] instr_count, instr_count2;

  cpu_multicycle_ctrl_if mif ();
  cpu_multicycle_ctrl_if mif2 ();

  assign mif.imem_ready  = ready;
  assign mif.imem_rdata  = rdata;
  assign mif2.imem_ready = ready2;
  assign mif2.imem_rdata = rdata;

  cpu_multicycle_ctrl u_dut (
    .clk(clk), .rst(rst), .imem(mif.master), .alu_zero(alu_zero),
    .pc(pc), .ir(ir), .alu_en(alu_en), .rf_we(rf_we), .halted(halted),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  cpu_multicycle_ctrl #(.RESET_PC(32'hA000_0010)) u_dut2 (
    .clk(clk), .rst(rst2), .imem(mif2.master), .alu_zero(alu_zero),
    .pc(pc2), .ir(ir2), .alu_en(alu_en2), .rf_we(rf_we2), .halted(halted2),
    .illegal(illegal2), .state(state2), .instr_count(instr_count2)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_illegal;
  int          m_retired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef CTRL_PERF_CNT_EN
    return (m_retired >= 65535) ? 32'h0000_FFFF : 32'(m_retired);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_ir = 32'd0; m_illegal = 1'b0; m_retired = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, 32'd0);
    check({tag, "_ir"}, ir, 32'd0);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_req"}, 32'(mif.imem_req), 32'd1);
    check({tag, "_alu_en"}, 32'(alu_en), 32'd0);
    check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
    check({tag, "_cnt"}, 32'(instr_count), 32'd0);
  endtask

  // Called at a falling edge with the DUT in FETCH; fetches one instruction after
  // the given number of stall cycles and follows it until FETCH or HALT.
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic zero, input int stalls);
    int          op, imm, n, n_alu, n_rf, n_both, n_req;
    int          e_cyc, e_alu, e_rf;
    logic [31:0] e_pc;
    logic [2:0]  e_state;
    logic        e_halt;
    alu_zero = zero;
    for (int i = 0; i < stalls; i++) begin
      ready = 1'b0;
      rdata = $urandom;
      @(negedge clk);
      check({tag, "_stall_state"}, 32'(state), 32'd0);
      check({tag, "_stall_pc"}, pc, m_pc);
      check({tag, "_stall_ir"}, ir, m_ir);
    end
    ready = 1'b1;
    rdata = instr;
    @(negedge clk);
    m_ir = instr;
    check({tag, "_ir"}, ir, instr);
    check({tag, "_decode"}, 32'(state), 32'd1);
    n = 0; n_alu = 0; n_rf = 0; n_both = 0; n_req = 0;
    while (state != 3'd0 && state != 3'd6 && n < 10) begin
      n++;
      n_alu  += int'(alu_en);
      n_rf   += int'(rf_we);
      n_both += int'(alu_en & rf_we);
      n_req  += int'(mif.imem_req);
      ready = 1'($urandom);
      rdata = $urandom;
      @(negedge clk);
    end

    op = int'(instr[31:26]);
    e_state = 3'd0;
    e_halt  = 1'b0;
    e_alu   = 0;
    e_rf    = 0;
    if (op <= 7) begin
      e_cyc = 3; e_alu = 1; e_rf = 1; e_pc = m_pc + 4; m_retired++;
    end else if (op == 8) begin
      imm = instr[15] ? int'(instr[15:0]) - 65536 : int'(instr[15:0]);
      e_cyc = 2; e_alu = 1;
      e_pc = zero ? m_pc + 4 + imm * 4 : m_pc + 4;
      m_retired++;
    end else if (op == 9) begin
      e_cyc = 2;
      e_pc = (m_pc & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
      m_retired++;
    end else if (op == 63) begin
      e_cyc = 1; e_pc = m_pc; e_state = 3'd6; e_halt = 1'b1; m_retired++;
    end else begin
      e_cyc = 1; e_pc = m_pc + 4; m_illegal = 1'b1;
    end
    m_pc = e_pc;

    check({tag, "_cycles"}, 32'(n), 32'(e_cyc));
    check({tag, "_alu_cycles"}, 32'(n_alu), 32'(e_alu));
    check({tag, "_rf_cycles"}, 32'(n_rf), 32'(e_rf));
    check({tag, "_overlap"}, 32'(n_both), 32'd0);
    check({tag, "_req_busy"}, 32'(n_req), 32'd0);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_state"}, 32'(state), 32'(e_state));
    check({tag, "_halted"}, 32'(halted), 32'(e_halt));
    check({tag, "_illegal"}, 32'(illegal), 32'(m_illegal));
    check({tag, "_cnt"}, 32'(instr_count), exp_cnt());
  endtask

  initial begin
    logic [31:0] w;
    int          pick;
    rst = 1'b1; rst2 = 1'b1; ready = 1'b0; ready2 = 1'b0; rdata = 32'd0; alu_zero = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    run_instr("alu", {6'd2, 26'h0}, 1'b0, 0);
    check("alu_pc4", pc, 32'h4);
    run_instr("jmp1", {6'd9, 26'h40}, 1'b0, 0);
    check("jmp1_pc", pc, 32'h100);
    run_instr("br_taken", {6'd8, 10'h0, 16'hFFFE}, 1'b1, 0);
    check("br_taken_pc", pc, 32'hFC);
    run_instr("jmp2", {6'd9, 26'h40}, 1'b0, 0);
    run_instr("br_not", {6'd8, 10'h0, 16'hFFFE}, 1'b0, 0);
    check("br_not_pc", pc, 32'h104);
    run_instr("stall", {6'd5, 26'h123_4567}, 1'b0, 5);
    run_instr("illegal", {6'd12, 26'h0}, 1'b0, 0);
    check("illegal_flag", 32'(illegal), 32'd1);

    for (int k = 0; k < 150; k++) begin
      pick = $urandom_range(0, 9);
      w = $urandom;
      if (pick < 4)       w[31:26] = 6'($urandom_range(0, 7));
      else if (pick < 7)  w[31:26] = 6'd8;
      else if (pick < 9)  w[31:26] = 6'd9;
      else                w[31:26] = 6'($urandom_range(10, 62));
      run_instr("rand", w, 1'($urandom), $urandom_range(0, 3));
    end

    ready = 1'b1;
    rdata = {6'd3, 26'h0};
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check("mid_exec_state", 32'(state), 32'd2);
    check("mid_exec_alu_en", 32'(alu_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_exec_rst");
    rst = 1'b0;
    model_reset();

    run_instr("alu2", {6'd0, 26'h3FF_FFFF}, 1'b1, 1);
    run_instr("halt", {6'd63, 26'h0}, 1'b0, 0);
    for (int k = 0; k < 20; k++) begin
      ready = 1'($urandom);
      rdata = $urandom;
      @(negedge clk);
      check("halt_state", 32'(state), 32'd6);
      check("halt_req", 32'(mif.imem_req), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_strobes", 32'({alu_en, rf_we}), 32'd0);
      check("halt_pc", pc, m_pc);
    end
    check("halt_cnt", 32'(instr_count), exp_cnt());

    check("rpc_reset_pc", pc2, 32'hA000_0010);
    rst2 = 1'b0;
    ready2 = 1'b1;
    rdata = {6'd9, 26'h40};
    @(negedge clk);
    check("rpc_decode", 32'(state2), 32'd1);
    ready2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rpc_jump_state", 32'(state2), 32'd0);
    check("rpc_jump_pc", pc2, 32'hA000_0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
